memory_arbiter: RTL and testbench

Sequences the single shared RAM port between the instruction-fetch requester and the data requester of the pipelined datapath. Data accesses have priority. A starvation counter forces an instruction grant after a run of back-to-back data grants. The block holds each grant until the RAM reports completion, so only one transaction is ever outstanding. It sits between the datapath/cache side and the RAM model.

---
 rtl/memory_arbiter.sv | 116 +++++++++++
 tb/tb_memory_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Arbiter for the single shared RAM port between instruction fetch and data access.
// Data wins by default; a run counter forces an instruction grant after MAX_DRUN data grants.
module memory_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_DRUN = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [DATA_W-1:0] iload,
   output logic              iwait,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic [DATA_W-1:0] dload,
   output logic              dwait,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ram_ready,
   output logic [3:0]        drun
);

   typedef enum logic [1:0] {StIdle, StDgnt, StIgnt} state_e;

   localparam logic [3:0] MaxDrun = 4'(MAX_DRUN);

   state_e     state_q, state_d;
   logic [3:0] drun_q, drun_d;
   logic       dreq;
   logic       arb;

   assign dreq = dREN | dWEN;
   assign drun = drun_q;

   always_comb begin
      state_d  = state_q;
      drun_d   = drun_q;
      arb      = 1'b0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;

      unique case (state_q)
         StIdle: arb = 1'b1;
         StDgnt: begin
            if (dreq) begin
               // A combined read+write request is carried out as a write.
               ramWEN   = dWEN;
               ramREN   = dREN & ~dWEN;
               ramaddr  = daddr;
               ramstore = dstore;
               if (ram_ready) begin
                  dwait = 1'b0;
                  dload = ramload;
                  if (iREN) begin
                     drun_d = (drun_q == 4'hf) ? 4'hf : drun_q + 4'd1;
                  end else begin
                     drun_d = 4'd0;
                  end
                  arb = 1'b1;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StIgnt: begin
            if (iREN) begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ram_ready) begin
                  iwait  = 1'b0;
                  iload  = ramload;
                  drun_d = 4'd0;
                  arb    = 1'b1;
               end
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Re-arbitration on completion sees the already-updated run count.
      if (arb) begin
         if (iREN && (!dreq || (drun_d >= MaxDrun))) begin
            state_d = StIgnt;
         end else if (dreq) begin
            state_d = StDgnt;
         end else begin
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         drun_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         drun_q  <= drun_d;
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios, then random requesters against a
// transaction-level arbitration model and a read-data scoreboard.
module tb_memory_arbiter;

   localparam int MaxDrun = 4;

   typedef enum int {OwnNone, OwnI, OwnD} own_e;
   typedef struct {
      logic        wr;
      logic [31:0] val;
   } dexp_t;

   logic        CLK, RST;
   logic        iREN, dREN, dWEN, ram_ready;
   logic [31:0] iaddr, daddr, dstore;
   logic [31:0] iload, dload, ramaddr, ramstore, ramload;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [3:0]  drun;

   int          checks = 0;
   int          failures = 0;
   logic        ram_force;
   logic [31:0] force_val;
   logic [31:0] dmem [64];
   logic [31:0] shadow [64];
   logic [31:0] iexp [$];
   dexp_t       dexp [$];
   own_e        own;
   int          drun_m;
   bit          i_done, d_done;

   int cd_iw   [8] = '{1, 1, 1, 1, 1, 0, 1, 1};
   int cd_dw   [8] = '{1, 0, 0, 0, 0, 1, 0, 0};
   int cd_drun [8] = '{0, 0, 1, 2, 3, 4, 0, 1};

   memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DRUN(MaxDrun)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ram_ready(ram_ready), .drun(drun)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [31:0] ifn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // RAM model: instruction region is a fixed pattern, data region (bit 6) is writable.
   assign ramload = ram_force ? force_val :
                    (ramaddr[6] ? dmem[ramaddr[5:0]] : ifn(ramaddr));

   always @(negedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 64; i++) dmem[i] <= '0;
      end else if (ramWEN && ram_ready) begin
         dmem[ramaddr[5:0]] <= ramstore;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
      iaddr = '0; daddr = '0; dstore = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      RST = 1;
      step();
      RST = 0;
   endtask

   function automatic own_e decide(input int dr);
      if (iREN && (!(dREN || dWEN) || dr >= MaxDrun)) return OwnI;
      if (dREN || dWEN) return OwnD;
      return OwnNone;
   endfunction

   task automatic model_step();
      own_e  nx;
      logic  e_ren, e_wen, e_iw, e_dw;
      dexp_t de;
      e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
      nx = own;
      chk("rnd_drun", 32'(drun), 32'(drun_m));
      case (own)
         OwnNone: nx = decide(drun_m);
         OwnI: begin
            if (!iREN) begin
               nx = OwnNone;
            end else begin
               e_ren = 1;
               chk("rnd_iaddr", ramaddr, iaddr);
               if (ram_ready) begin
                  e_iw = 0;
                  drun_m = 0;
                  nx = decide(drun_m);
               end
            end
         end
         default: begin
            if (!(dREN || dWEN)) begin
               nx = OwnNone;
            end else begin
               e_wen = dWEN;
               e_ren = !dWEN;
               chk("rnd_daddr", ramaddr, daddr);
               chk("rnd_dstore", ramstore, dstore);
               if (ram_ready) begin
                  e_dw = 0;
                  drun_m = iREN ? ((drun_m < 15) ? drun_m + 1 : 15) : 0;
                  nx = decide(drun_m);
               end
            end
         end
      endcase
      chk("rnd_ramREN", 32'(ramREN), 32'(e_ren));
      chk("rnd_ramWEN", 32'(ramWEN), 32'(e_wen));
      chk("rnd_iwait", 32'(iwait), 32'(e_iw));
      chk("rnd_dwait", 32'(dwait), 32'(e_dw));
      if (!iwait) begin
         if (iexp.size() == 0) chk("rnd_iq_empty", 32'(iexp.size()), 32'd1);
         else chk("rnd_iload", iload, iexp.pop_front());
      end
      if (!dwait) begin
         if (dexp.size() == 0) begin
            chk("rnd_dq_empty", 32'(dexp.size()), 32'd1);
         end else begin
            de = dexp.pop_front();
            if (!de.wr) chk("rnd_dload", dload, de.val);
         end
      end
      own = nx;
   endtask

   initial begin
      ram_force = 0;
      force_val = '0;
      clear_inputs();
      RST = 1;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_ramREN", 32'(ramREN), 0);
      chk("rst_ramWEN", 32'(ramWEN), 0);
      chk("rst_iwait", 32'(iwait), 1);
      chk("rst_dwait", 32'(dwait), 1);
      chk("rst_drun", 32'(drun), 0);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_loads", iload | dload, 0);
      RST = 0;
      step();

      // Data-only read with completion on cycle 3.
      do_reset();
      ram_force = 1;
      force_val = 32'hDEAD_BEEF;
      for (int c = 0; c < 4; c++) begin
         if (c == 0) begin dREN = 1; daddr = 32'h100; end
         ram_ready = (c == 3);
         @(negedge CLK);
         chk("do_ramREN", 32'(ramREN), (c >= 1) ? 1 : 0);
         chk("do_ramaddr", ramaddr, (c >= 1) ? 32'h100 : 0);
         chk("do_dwait", 32'(dwait), (c == 3) ? 0 : 1);
         chk("do_dload", dload, (c == 3) ? 32'hDEAD_BEEF : 0);
         chk("do_iwait", 32'(iwait), 1);
         step();
      end
      ram_force = 0;
      clear_inputs();

      // Contention with ready every cycle: D,D,D,D,I,D.
      do_reset();
      iREN = 1; iaddr = 32'h10; dWEN = 1; daddr = 32'h40; dstore = 32'h1; ram_ready = 1;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         chk("ct_iwait", 32'(iwait), 32'(cd_iw[k]));
         chk("ct_dwait", 32'(dwait), 32'(cd_dw[k]));
         chk("ct_drun", 32'(drun), 32'(cd_drun[k]));
         if (k == 5) chk("ct_iaddr", ramaddr, 32'h10);
         step();
      end
      clear_inputs();

      // Simultaneous read and write is a write.
      do_reset();
      dREN = 1; dWEN = 1; dstore = 32'h55; daddr = 32'h44;
      @(negedge CLK);
      chk("rw_idle_ramWEN", 32'(ramWEN), 0);
      step();
      @(negedge CLK);
      chk("rw_ramWEN", 32'(ramWEN), 1);
      chk("rw_ramREN", 32'(ramREN), 0);
      chk("rw_ramstore", ramstore, 32'h55);
      step();
      ram_ready = 1;
      @(negedge CLK);
      chk("rw_dwait", 32'(dwait), 0);
      step();
      clear_inputs();

      // Instruction withdrawal with a non-zero run count.
      do_reset();
      iREN = 1; iaddr = 32'h20; dWEN = 1; daddr = 32'h48; ram_ready = 1;
      repeat (5) begin @(negedge CLK); step(); end
      ram_ready = 0; dWEN = 0;
      @(negedge CLK);
      chk("wd_gnt_ramREN", 32'(ramREN), 1);
      chk("wd_gnt_addr", ramaddr, 32'h20);
      chk("wd_gnt_drun", 32'(drun), 4);
      step();
      iREN = 0;
      @(negedge CLK);
      chk("wd_ramREN", 32'(ramREN), 0);
      chk("wd_iwait", 32'(iwait), 1);
      chk("wd_drun", 32'(drun), 4);
      step();
      iREN = 1;
      @(negedge CLK);
      chk("wd_idle_ramREN", 32'(ramREN), 0);
      chk("wd_idle_drun", 32'(drun), 4);
      step();
      @(negedge CLK);
      chk("wd_regnt_ramREN", 32'(ramREN), 1);
      step();
      clear_inputs();

      // Asynchronous reset in the middle of a data write grant.
      do_reset();
      dWEN = 1; daddr = 32'h4C; dstore = 32'hA5;
      @(negedge CLK);
      step();
      @(negedge CLK);
      chk("ar_pre_ramWEN", 32'(ramWEN), 1);
      #1 RST = 1;
      #1;
      chk("ar_ramWEN", 32'(ramWEN), 0);
      chk("ar_dwait", 32'(dwait), 1);
      chk("ar_ramaddr", ramaddr, 0);
      #1 RST = 0;
      #1;
      chk("ar_idle_ramWEN", 32'(ramWEN), 0);
      @(negedge CLK);
      chk("ar_regnt_ramWEN", 32'(ramWEN), 1);
      step();
      clear_inputs();

      // Random phase.
      do_reset();
      for (int i = 0; i < 64; i++) shadow[i] = '0;
      own = OwnNone;
      drun_m = 0;
      i_done = 0;
      d_done = 0;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               int gap, t;
               gap = $urandom_range(0, 2);
               if (gap != 0) begin
                  iREN = 0;
                  repeat (gap) step();
               end
               iREN = 1;
               iaddr = 32'($urandom_range(0, 63));
               iexp.push_back(ifn(iaddr));
               t = 0;
               do begin @(negedge CLK); t++; end while (iwait && t < 200);
               if (t >= 200) chk("rnd_i_timeout", 32'(t), 32'd0);
               step();
            end
            iREN = 0;
            i_done = 1;
         end
         begin
            for (int n = 0; n < 40; n++) begin
               int gap, t, op, idx;
               dexp_t e;
               gap = $urandom_range(0, 2);
               if (gap != 0) begin
                  dREN = 0; dWEN = 0;
                  repeat (gap) step();
               end
               op = $urandom_range(0, 2);
               idx = $urandom_range(0, 63);
               daddr = 32'h40 | 32'(idx);
               dstore = $urandom;
               dREN = (op != 1);
               dWEN = (op != 0);
               e.wr = dWEN;
               e.val = shadow[idx];
               if (dWEN) shadow[idx] = dstore;
               dexp.push_back(e);
               t = 0;
               do begin @(negedge CLK); t++; end while (dwait && t < 200);
               if (t >= 200) chk("rnd_d_timeout", 32'(t), 32'd0);
               step();
            end
            dREN = 0; dWEN = 0;
            d_done = 1;
         end
         begin
            while (!(i_done && d_done)) begin
               ram_ready = ($urandom_range(0, 3) != 0);
               step();
            end
            ram_ready = 0;
         end
         begin
            while (!(i_done && d_done)) begin
               @(negedge CLK);
               model_step();
            end
         end
      join
      chk("rnd_iq_drained", 32'(iexp.size()), 0);
      chk("rnd_dq_drained", 32'(dexp.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
